sad_stream_engine: RTL and testbench

//   Pipelined sum-of-absolute-differences engine; successor to the single-cycle SAD datapath.

---
 rtl/sad_stream_engine_pkg.sv | 49 ++++
 rtl/sad_stream_engine_if.sv | 33 +++
 rtl/sad_stream_engine_adder_tree.sv | 19 +
 rtl/sad_stream_engine.sv | 196 +++++++++++++++++++
 tb/tb_sad_stream_engine.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_stream_engine_pkg.sv
// Shared widths and arithmetic helpers for the SAD stream engine.
// Optional min tracker is enabled by defining SAD_MINTRACK_EN.
package sad_stream_engine_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LANES     = 4;
  localparam int DEF_MAX_BEATS = 64;
  localparam int DEF_IDX_W     = 8;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sum_width(input int dw, input int lanes);
    return dw + clog2(lanes);
  endfunction

  function automatic int acc_width(input int dw, input int lanes, input int beats);
    return dw + clog2(lanes) + clog2(beats);
  endfunction

  // Unsigned add clamped to the largest w-bit value; ovf flags the clamp.
  function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
    sat_res_t    r;
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    if (s > mx) begin
      r.ovf = 1'b1;
      r.val = mx[31:0];
    end else begin
      r.ovf = 1'b0;
      r.val = s[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sad_stream_engine_if.sv
// Pixel-pair input stream, block result stream and min-tracker signals.
interface sad_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16,
  parameter int IDX_W  = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_sad;
  logic                    out_sat;
  logic [IDX_W-1:0]        out_idx;
  logic                    min_clear;
  logic [ACC_W-1:0]        min_sad;
  logic [IDX_W-1:0]        min_idx;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready, min_clear,
    output in_ready, out_valid, out_sad, out_sat, out_idx, min_sad, min_idx
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready, min_clear,
    input  in_ready, out_valid, out_sad, out_sat, out_idx, min_sad, min_idx
  );

endinterface

// File: rtl/sad_stream_engine_adder_tree.sv
// Combinational reduction of LANES unsigned DATA_W values into one sum.
module sad_stream_engine_adder_tree #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int SUM_W  = 10
) (
  input  logic [LANES*DATA_W-1:0] diffs,
  output logic [SUM_W-1:0]        sum
);

  // Zero-extend every lane to the full sum width before adding
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(diffs[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/sad_stream_engine.sv
// Pipelined SAD engine: |A-B| stage, adder-tree stage, accumulate stage, result register.
// Define SAD_MINTRACK_EN to build the minimum-SAD tracker.
module sad_stream_engine
  import sad_stream_engine_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  sad_stream_engine_if.slave  bus
);

  localparam int SUM_W = sum_width(DATA_W, LANES);
  localparam int ACC_W = acc_width(DATA_W, LANES, MAX_BEATS);
  localparam int PIX_W = LANES * DATA_W;

  logic             alive_r;
  logic             en_s;
  logic             accept_s;
  logic [PIX_W-1:0] diff_s;
  logic [PIX_W-1:0] s1_diff_r;
  logic             s1_valid_r;
  logic             s1_last_r;
  logic [SUM_W-1:0] tree_sum_s;
  logic [SUM_W-1:0] s2_sum_r;
  logic             s2_valid_r;
  logic             s2_last_r;
  logic [ACC_W-1:0] acc_r;
  logic             sat_r;
  sat_res_t         add_s;
  logic [ACC_W-1:0] total_s;
  logic             ovf_s;
  logic [ACC_W-1:0] s3_sum_r;
  logic             s3_sat_r;
  logic             s3_valid_r;
  logic             s3_last_r;
  logic             load_s;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_sad_r;
  logic             out_sat_r;
  logic [IDX_W-1:0] out_idx_r;
  logic [IDX_W-1:0] cnt_r;
  logic             unused_s;

  // A held, unconsumed result freezes every stage at once
  assign en_s         = !(out_valid_r && !bus.out_ready);
  assign accept_s     = bus.in_valid && alive_r && en_s;
  assign load_s       = en_s && s3_valid_r && s3_last_r;
  assign bus.in_ready = alive_r && en_s;

  // Keeps the input closed while reset is asserted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive_r <= 1'b0;
    else     alive_r <= 1'b1;
  end

  // Per-lane unsigned absolute difference
  always_comb begin
    diff_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_a[i*DATA_W +: DATA_W] >= bus.in_b[i*DATA_W +: DATA_W]) begin
        diff_s[i*DATA_W +: DATA_W] = bus.in_a[i*DATA_W +: DATA_W] - bus.in_b[i*DATA_W +: DATA_W];
      end else begin
        diff_s[i*DATA_W +: DATA_W] = bus.in_b[i*DATA_W +: DATA_W] - bus.in_a[i*DATA_W +: DATA_W];
      end
    end
  end

  sad_stream_engine_adder_tree #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_tree (
    .diffs (s1_diff_r),
    .sum   (tree_sum_s)
  );

  // Accumulator plus the incoming beat sum, clamped to ACC_W bits
  always_comb begin
    add_s   = sat_add(32'(acc_r), 32'(s2_sum_r), ACC_W);
    total_s = add_s.val[ACC_W-1:0];
    ovf_s   = add_s.ovf;
  end

  // S1 difference registers and S2 sum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_diff_r  <= '0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sum_r   <= '0;
    end else if (en_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= accept_s && bus.in_last;
      s1_diff_r  <= diff_s;
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_sum_r   <= tree_sum_s;
    end
  end

  // S3: running accumulation; a last beat hands off the total and restarts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r      <= '0;
      sat_r      <= 1'b0;
      s3_valid_r <= 1'b0;
      s3_last_r  <= 1'b0;
      s3_sum_r   <= '0;
      s3_sat_r   <= 1'b0;
    end else if (en_s) begin
      s3_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        s3_last_r <= s2_last_r;
        s3_sum_r  <= total_s;
        s3_sat_r  <= sat_r || ovf_s;
        if (s2_last_r) begin
          acc_r <= '0;
          sat_r <= 1'b0;
        end else begin
          acc_r <= total_s;
          sat_r <= sat_r || ovf_s;
        end
      end
    end
  end

  // Result register; a load in the consuming cycle keeps out_valid high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sad_r   <= '0;
      out_sat_r   <= 1'b0;
      out_idx_r   <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_sad_r   <= s3_sum_r;
      out_sat_r   <= s3_sat_r;
      out_idx_r   <= cnt_r;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_sad   = out_sad_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_idx   = out_idx_r;

`ifdef SAD_MINTRACK_EN
  logic [ACC_W-1:0] min_sad_r;
  logic [IDX_W-1:0] min_idx_r;

  // Block index and strict-less-than minimum; clear has priority over a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      min_sad_r <= '1;
      min_idx_r <= '0;
    end else if (bus.min_clear) begin
      cnt_r     <= '0;
      min_sad_r <= '1;
      min_idx_r <= '0;
    end else if (load_s) begin
      cnt_r <= cnt_r + IDX_W'(1);
      if (s3_sum_r < min_sad_r) begin
        min_sad_r <= s3_sum_r;
        min_idx_r <= cnt_r;
      end
    end
  end

  assign bus.min_sad = min_sad_r;
  assign bus.min_idx = min_idx_r;
  assign unused_s    = ^add_s.val[31:ACC_W];
`else
  // Block index counter, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load_s) begin
      cnt_r <= cnt_r + IDX_W'(1);
    end
  end

  assign bus.min_sad = '0;
  assign bus.min_idx = '0;
  assign unused_s    = ^{add_s.val[31:ACC_W], bus.min_clear};
`endif

endmodule

// File: tb/tb_sad_stream_engine.sv
// Self-checking bench for sad_stream_engine against a block-level SAD reference model.
module tb_sad_stream_engine;
  import sad_stream_engine_pkg::*;

  localparam int DW    = 8;
  localparam int LN    = 4;
  localparam int IW    = 8;
  localparam int PIX   = LN * DW;
  localparam int ACC_M = acc_width(DW, LN, 64);
  localparam int ACC_S = acc_width(DW, LN, 4);
  localparam longint MAX_M = (longint'(1) << ACC_M) - 1;
  localparam longint MAX_S = (longint'(1) << ACC_S) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_stream_engine_if #(.DATA_W(DW), .LANES(LN), .ACC_W(ACC_M), .IDX_W(IW)) bus ();
  sad_stream_engine_if #(.DATA_W(DW), .LANES(LN), .ACC_W(ACC_S), .IDX_W(IW)) bus_s ();

  sad_stream_engine #(.DATA_W(DW), .LANES(LN), .MAX_BEATS(64), .IDX_W(IW)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  sad_stream_engine #(.DATA_W(DW), .LANES(LN), .MAX_BEATS(4), .IDX_W(IW)) u_dut_small (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  typedef struct {
    longint sad;
    bit     sat;
    int     idx;
  } exp_t;

  int     checks = 0;
  int     failures = 0;
  exp_t   exp_q[$];
  longint blk_sum = 0;
  int     idx_m = 0;
  longint min_m = MAX_M;
  int     min_idx_m = 0;
  bit     release_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint beat_sad(input logic [PIX-1:0] a, input logic [PIX-1:0] b);
    longint s;
    int x, y;
    s = 0;
    for (int i = 0; i < LN; i++) begin
      x = int'(a[i*DW +: DW]);
      y = int'(b[i*DW +: DW]);
      s += (x > y) ? longint'(x - y) : longint'(y - x);
    end
    return s;
  endfunction

  task automatic model_reset();
    blk_sum = 0;
    exp_q.delete();
    idx_m = 0;
    min_m = MAX_M;
    min_idx_m = 0;
  endtask

  task automatic send_beat(input logic [PIX-1:0] a, input logic [PIX-1:0] b, input bit last);
    int waited;
    bit ok;
    exp_t e;
    bus.in_a = a; bus.in_b = b; bus.in_last = last; bus.in_valid = 1'b1;
    waited = 0; ok = 1'b0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
        waited++;
        if (release_ok) bus.out_ready = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) begin
      chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      blk_sum += beat_sad(a, b);
      if (last) begin
        e.sad = (blk_sum > MAX_M) ? MAX_M : blk_sum;
        e.sat = (blk_sum > MAX_M);
        e.idx = idx_m;
        exp_q.push_back(e);
        idx_m = (idx_m + 1) % (1 << IW);
        blk_sum = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_min_clear();
    bus.min_clear = 1'b1;
    @(posedge clk); #1;
    bus.min_clear = 1'b0;
`ifdef SAD_MINTRACK_EN
    idx_m = 0;
    min_m = MAX_M;
    min_idx_m = 0;
`endif
  endtask

  // Scoreboard: every handshake consumes the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_sad", 64'(bus.out_sad), 64'(e.sad));
        chk("out_sat", 64'(bus.out_sat), 64'(e.sat));
        chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
`ifdef SAD_MINTRACK_EN
        if (e.sad < min_m) begin
          min_m = e.sad;
          min_idx_m = e.idx;
        end
        chk("min_sad_track", 64'(bus.min_sad), 64'(min_m));
        chk("min_idx_track", 64'(bus.min_idx), 64'(min_idx_m));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PIX-1:0] a, b;
    int len, k;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1; bus.min_clear = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_a = '0; bus_s.in_b = '0; bus_s.in_last = 1'b0;
    bus_s.out_ready = 1'b1; bus_s.min_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_sad", 64'(bus.out_sad), 64'd0);
    chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
    chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
`ifdef SAD_MINTRACK_EN
    chk("rst_min_sad", 64'(bus.min_sad), 64'(MAX_M));
`else
    chk("rst_min_sad", 64'(bus.min_sad), 64'd0);
`endif
    chk("rst_min_idx", 64'(bus.min_idx), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single beat block and its 3-cycle latency
    send_beat({8'd40, 8'd30, 8'd20, 8'd10}, {8'd50, 8'd30, 8'd25, 8'd0}, 1'b1);
    @(posedge clk); #1;
    chk("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge3_valid", 64'(bus.out_valid), 64'd1);
    chk("one_beat_sad", 64'(bus.out_sad), 64'd25);
    chk("one_beat_idx", 64'(bus.out_idx), 64'd0);
    drain();

    // 16 beats of maximum difference, then a fresh block
    for (int i = 0; i < 16; i++) send_beat({PIX{1'b1}}, '0, (i == 15));
    send_beat({8'd1, 8'd1, 8'd1, 8'd1}, '0, 1'b1);
    drain();

    // Stall: three blocks queue up behind a held result
    bus.out_ready = 1'b0;
    send_beat({8'd9, 8'd8, 8'd7, 8'd6}, '0, 1'b1);
    send_beat({8'd1, 8'd2, 8'd3, 8'd4}, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    send_beat('0, {8'd100, 8'd0, 8'd0, 8'd1}, 1'b1);
    idle(10);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_held_sad", 64'(bus.out_sad), 64'(exp_q[0].sad));
    drain();

    // Randomized blocks with bubbles and back-pressure
    release_ok = 1'b1;
    for (int blk = 0; blk < 25; blk++) begin
      len = $urandom_range(1, 8);
      for (k = 0; k < len; k++) begin
        a = $urandom;
        b = $urandom;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        send_beat(a, b, (k == len - 1));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    release_ok = 1'b0;
    drain();

    // Min tracker: SADs 50, 30, 30, 70
    pulse_min_clear();
`ifdef SAD_MINTRACK_EN
    chk("clr_min_sad", 64'(bus.min_sad), 64'(MAX_M));
    chk("clr_min_idx", 64'(bus.min_idx), 64'd0);
`endif
    send_beat({24'd0, 8'd50}, '0, 1'b1);
    send_beat({24'd0, 8'd30}, '0, 1'b1);
    send_beat('0, {24'd0, 8'd30}, 1'b1);
    send_beat({24'd0, 8'd70}, '0, 1'b1);
    drain();
`ifdef SAD_MINTRACK_EN
    chk("min_sad_30", 64'(bus.min_sad), 64'd30);
    chk("min_idx_1", 64'(bus.min_idx), 64'd1);
    pulse_min_clear();
    chk("clr2_min_sad", 64'(bus.min_sad), 64'(MAX_M));
    chk("clr2_min_idx", 64'(bus.min_idx), 64'd0);
`else
    chk("min_sad_off", 64'(bus.min_sad), 64'd0);
    chk("min_idx_off", 64'(bus.min_idx), 64'd0);
`endif

    // Saturation on the MAX_BEATS=4 instance: 8 beats of 1020
    chk("small_in_ready", 64'(bus_s.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus_s.in_a = {PIX{1'b1}}; bus_s.in_b = '0; bus_s.in_last = (i == 7); bus_s.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
    k = 0;
    while (!bus_s.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("sat_sad", 64'(bus_s.out_sad), 64'((8 * 1020 > MAX_S) ? MAX_S : 8 * 1020));
    chk("sat_flag", 64'(bus_s.out_sat), 64'd1);
    bus_s.in_a = {8'd4, 8'd3, 8'd2, 8'd1}; bus_s.in_b = '0; bus_s.in_last = 1'b1; bus_s.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
    k = 0;
    while (!bus_s.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("after_sat_sad", 64'(bus_s.out_sad), 64'd10);
    chk("after_sat_flag", 64'(bus_s.out_sat), 64'd0);
    chk("after_sat_idx", 64'(bus_s.out_idx), 64'd1);

    // Reset with a pending result and a partial block in flight
    bus.out_ready = 1'b0;
    send_beat({8'd5, 8'd5, 8'd5, 8'd5}, '0, 1'b1);
    send_beat({8'd200, 8'd200, 8'd200, 8'd200}, '0, 1'b0);
    send_beat({8'd200, 8'd200, 8'd200, 8'd200}, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_sad", 64'(bus.out_sad), 64'd0);
    chk("mid_rst_out_idx", 64'(bus.out_idx), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat({8'd8, 8'd7, 8'd6, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("post_rst_sad", 64'(bus.out_sad), 64'd22);
    chk("post_rst_idx", 64'(bus.out_idx), 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
